// File: rtl/dtc_sched_pkg.sv
// ============================================================================
// dtc_sched_pkg : shared FSM state encoding and default widths for dtc_sched
// Rev 1.0
// ============================================================================
`default_nettype none

package dtc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 7;
  localparam int OUT_W_DEF = 10;

endpackage

`default_nettype wire

// File: rtl/dtc_rr_arb.sv
// ============================================================================
// dtc_rr_arb : combinational round-robin arbiter, search from ptr upward with wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module dtc_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [NREQ-1:0] hi;
  logic [NREQ-1:0] pick;

  // Requests at or above ptr take precedence; otherwise wrap to the lowest one.
  always_comb begin
    hi    = '0;
    pick  = '0;
    idx   = '0;
    grant = '0;
    any   = |req;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = req[i] && (i >= int'(ptr));
    end
    pick = (|hi) ? hi : req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = any && (idx == IDW'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/dtc_sched.sv
// ============================================================================
// dtc_sched : round-robin scheduler sharing one external classifier; optional
//             per-requester grant counters under DTC_SCHED_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module dtc_sched
  import dtc_sched_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int IN_W  = IN_W_DEF,
  parameter  int OUT_W = OUT_W_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [IN_W-1:0]    cls_inp,
  input  logic [OUT_W-1:0]   cls_outp,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [OUT_W-1:0]   rsp_data,
  output logic [IDW-1:0]     rsp_id
`ifdef DTC_SCHED_STATS_EN
  ,
  input  logic [IDW-1:0]     stat_sel,
  input  logic               stat_clr,
  output logic [15:0]        stat_cnt
`endif
);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] win_grant;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic            accept;
  logic [IN_W-1:0] lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] = req_data[i*IN_W +: IN_W];
  end

  dtc_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Outputs are gated by rst so they read idle for the whole reset pulse.
  assign accept    = (state == IDLE) && win_any && !rst;
  assign req_ready = accept ? win_grant : '0;
  assign rsp_valid = (state == RESP) && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_any) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cls_inp  <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cls_inp <= lane[win_idx];
        rsp_id  <= win_idx;
        ptr     <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
      if (state == EVAL) begin
        rsp_data <= cls_outp;
      end
    end
  end

`ifdef DTC_SCHED_STATS_EN
  logic [15:0] cnt [NREQ];

  // Clear beats a same-cycle grant; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt[i] <= '0;
      end
    end else if (accept && (cnt[win_idx] != 16'hFFFF)) begin
      cnt[win_idx] <= cnt[win_idx] + 16'd1;
    end
    if (rst) begin
      stat_cnt <= '0;
    end else begin
      stat_cnt <= cnt[stat_sel];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dtc_sched.sv
// ============================================================================
// tb_dtc_sched : directed table-driven bench for dtc_sched with classifier stub
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dtc_sched;

  localparam int NREQ  = 4;
  localparam int IN_W  = 7;
  localparam int OUT_W = 10;
  localparam int IDW   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*IN_W-1:0] req_data;
  logic [IN_W-1:0]    cls_inp;
  logic [OUT_W-1:0]   cls_outp;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [OUT_W-1:0]   rsp_data;
  logic [IDW-1:0]     rsp_id;
`ifdef DTC_SCHED_STATS_EN
  logic [IDW-1:0]     stat_sel;
  logic               stat_clr;
  logic [15:0]        stat_cnt;
`endif

  always #5 clk = ~clk;

  assign cls_outp = {3'b101, cls_inp};

  dtc_sched #(
    .NREQ  (NREQ),
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .cls_inp   (cls_inp),
    .cls_outp  (cls_outp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef DTC_SCHED_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]  mask;
    logic [IN_W-1:0]  data;
    int               stall;
    logic [NREQ-1:0]  exp_ready;
    logic [IDW-1:0]   exp_id;
    logic [OUT_W-1:0] exp_rsp;
    logic [NREQ-1:0]  exp_next;
  } vec_t;

  vec_t vecs [6];

  // One full transaction: grant in IDLE, EVAL, RESP with 'stall' held cycles,
  // then completion and the re-grant visible in the following IDLE cycle.
  task automatic run_txn(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*IN_W +: IN_W] = (i == int'(v.exp_id)) ? v.data : ~v.data;
    end
    req_valid = v.mask;
    rsp_ready = 1'b0;
    #1 check("ready_idle", req_ready, v.exp_ready);
    @(negedge clk);
    #1;
    check("ready_eval", req_ready, 0);
    check("valid_eval", rsp_valid, 0);
    check("cls_inp", cls_inp, v.data);
    @(negedge clk);
    for (int s = 0; s < v.stall; s++) begin
      #1;
      check("valid_hold", rsp_valid, 1);
      check("data_hold", rsp_data, v.exp_rsp);
      check("id_hold", rsp_id, v.exp_id);
      check("ready_hold", req_ready, 0);
      @(negedge clk);
    end
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, v.exp_rsp);
    check("rsp_id", rsp_id, v.exp_id);
    rsp_ready = 1'b1;
    #1 check("ready_complete", req_ready, 0);
    @(negedge clk);
    #1;
    check("valid_after", rsp_valid, 0);
    check("ready_resume", req_ready, v.exp_next);
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] exp_rdy;
    int              id;

    vecs[0] = '{4'b0100, 7'h15, 0, 4'b0100, 2'd2, 10'h295, 4'b0100};
    vecs[1] = '{4'b0001, 7'h00, 0, 4'b0001, 2'd0, 10'h280, 4'b0001};
    vecs[2] = '{4'b1010, 7'h7F, 1, 4'b0010, 2'd1, 10'h2FF, 4'b1000};
    vecs[3] = '{4'b1011, 7'h2A, 0, 4'b1000, 2'd3, 10'h2AA, 4'b0001};
    vecs[4] = '{4'b0110, 7'h01, 5, 4'b0010, 2'd1, 10'h281, 4'b0100};
    vecs[5] = '{4'b1001, 7'h55, 2, 4'b1000, 2'd3, 10'h2D5, 4'b0001};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
`ifdef DTC_SCHED_STATS_EN
    stat_sel  = '0;
    stat_clr  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_cls_inp", cls_inp, 0);
    req_valid = '0;
    rst = 1'b0;

    // Round robin with every requester valid and no backpressure.
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) req_data[i*IN_W +: IN_W] = 7'(8'h10 + i);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      id = (c / 3) % 4;
      exp_rdy = (c % 3 == 0) ? (4'b0001 << id) : 4'b0000;
      check("rr_ready", req_ready, exp_rdy);
      if (c % 3 == 2) begin
        check("rr_valid", rsp_valid, 1);
        check("rr_id", rsp_id, id);
        check("rr_data", rsp_data, {3'b101, 7'(8'h10 + id)});
      end else begin
        check("rr_valid_low", rsp_valid, 0);
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_txn(vecs[k]);
    end

    // Reset pulsed while EVAL is in progress.
    @(negedge clk);
    req_data  = {7'h11, 7'h22, 7'h33, 7'h44};
    req_valid = 4'b0100;
    #1 check("mid_ready", req_ready, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_cls_inp", cls_inp, 0);
    check("mid_rsp_id", rsp_id, 0);
    check("mid_rsp_data", rsp_data, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 check("mid_no_rsp", rsp_valid, 0);
    end
    req_valid = 4'b1111;
    #1 check("mid_ptr0", req_ready, 4'b0001);
    req_valid = '0;

`ifdef DTC_SCHED_STATS_EN
    stat_sel = 2'd1;
    for (int k = 0; k < 3; k++) begin
      run_txn('{4'b0010, 7'(k), 0, 4'b0010, 2'd1, {3'b101, 7'(k)}, 4'b0010});
    end
    @(negedge clk);
    #1 check("stat_cnt3", stat_cnt, 3);
    stat_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    #1 check("stat_other", stat_cnt, 0);
    stat_sel = 2'd1;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    @(negedge clk);
    #1 check("stat_clr", stat_cnt, 0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
